div_seq: RTL

//   Sequential signed 32-bit divider for the ALU's DIV op; counterpart to the combinational Booth multiplier.
//   Non-restoring radix-2 algorithm, one quotient bit per clock.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/div_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the divider and the control unit.
// Contents: datapath width, divider FSM state encoding, ALU opcode for DIV.
// No logic of its own.
package cpu_pkg;

  localparam int DATA_W = 32;

  // ALU opcode that routes an operation to the sequential divider.
  localparam logic [3:0] ALU_OP_DIV = 4'd9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division iteration.
// Ports: a_i/q_i partial remainder and quotient in, dv_i divisor magnitude,
//        a_o/q_o shifted-and-updated partial remainder and quotient out.
module div_step
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W:0]   a_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] dv_i,
  output logic [W:0]   a_o,
  output logic [W-1:0] q_o
);

  logic [W:0] a_sh;
  logic [W:0] dv_ext;

  always_comb begin
    // Shift {A,Q} left by one: the top quotient bit moves into A.
    a_sh   = {a_i[W-1:0], q_i[W-1]};
    dv_ext = {1'b0, dv_i};
    // Sign of the old A picks subtract (A >= 0) or add-back (A < 0).
    a_o    = a_i[W] ? (a_sh + dv_ext) : (a_sh - dv_ext);
    // New quotient bit is 1 when the updated remainder is non-negative.
    q_o    = {q_i[W-2:0], ~a_o[W]};
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider, non-restoring radix-2, one quotient bit per clock.
// Ports: start pulse captures dividend/divisor (IDLE or DONE only); busy while
//        working; done pulses once with P = {remainder, quotient} and div_zero.
//        Latency: done 34 cycles after accept, 2 cycles for a zero divisor.
module div_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t state_q, state_d;

  logic [WIDTH-1:0]   dd_q, dd_d;
  logic [WIDTH-1:0]   dv_q, dv_d;
  logic [WIDTH-1:0]   dv_mag_q, dv_mag_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     a_step;
  logic [WIDTH-1:0]   q_step;
  logic [WIDTH:0]     a_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               accept;

  div_step #(.W(WIDTH)) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .dv_i (dv_mag_q),
    .a_o  (a_step),
    .q_o  (q_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero divisor skips CALC; FIX then loads the flagged result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = (dv_q == '0) ? FIX : CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy     = (state_q == LOAD) || (state_q == CALC) || (state_q == FIX);
    done     = (state_q == DONE);
    div_zero = div_zero_q;
    P        = p_q;
  end

  // Datapath next values.
  always_comb begin
    dd_d       = dd_q;
    dv_d       = dv_q;
    dv_mag_d   = dv_mag_q;
    a_d        = a_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    p_d        = p_q;
    div_zero_d = div_zero_q;

    accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Final remainder correction and sign application, used only in FIX.
    a_fix = a_q[WIDTH] ? (a_q + {1'b0, dv_mag_q}) : a_q;
    quot  = q_neg_q ? -q_q : q_q;
    rem   = r_neg_q ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];

    if (accept) begin
      dd_d       = dividend;
      dv_d       = divisor;
      div_zero_d = 1'b0;
    end

    case (state_q)
      LOAD: begin
        // Magnitudes as unsigned; -2^(W-1) maps onto itself, which is correct unsigned.
        q_d      = dd_q[WIDTH-1] ? -dd_q : dd_q;
        dv_mag_d = dv_q[WIDTH-1] ? -dv_q : dv_q;
        a_d      = '0;
        cnt_d    = '0;
        q_neg_d  = dd_q[WIDTH-1] ^ dv_q[WIDTH-1];
        r_neg_d  = dd_q[WIDTH-1];
      end
      CALC: begin
        a_d   = a_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
      end
      FIX: begin
        if (dv_q == '0) begin
          p_d        = {dd_q, {WIDTH{1'b1}}};
          div_zero_d = 1'b1;
        end else begin
          p_d = {rem, quot};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dd_q       <= '0;
      dv_q       <= '0;
      dv_mag_q   <= '0;
      a_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      p_q        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      dd_q       <= dd_d;
      dv_q       <= dv_d;
      dv_mag_q   <= dv_mag_d;
      a_q        <= a_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      p_q        <= p_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule
